// File: rtl/div_sched_pkg.sv
// Shared types and constants for the round-robin divider scheduler.
package div_sched_pkg;

    localparam int WIDTH_DEF   = 16;
    localparam int NUM_REQ_MAX = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARB    = 3'd1,
        ST_LOAD_A = 3'd2,
        ST_LOAD_B = 3'd3,
        ST_SUB    = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

    // Folds (pointer + offset) back into 0..n-1. The operand never reaches 2n,
    // so a single conditional subtract is enough.
    function automatic logic [1:0] rr_wrap(input logic [2:0] sum, input logic [2:0] n);
        logic [2:0] w;
        w = (sum >= n) ? (sum - n) : sum;
        return w[1:0];
    endfunction

endpackage

// File: rtl/div_rr_scheduler_if.sv
// Requester-side bundle: request levels, operands and the completion response.
interface div_rr_scheduler_if
    import div_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_MAX,
    parameter int WIDTH   = WIDTH_DEF
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_dividend;
    logic [NUM_REQ*WIDTH-1:0] req_divisor;
    logic [NUM_REQ-1:0]       ack;
    logic [WIDTH-1:0]         quotient;
    logic [WIDTH-1:0]         remainder;
    logic                     err;
    logic                     busy;
    logic [1:0]               grant_id;

    modport master (
        output req, req_dividend, req_divisor,
        input  ack, quotient, remainder, err, busy, grant_id
    );

    modport slave (
        input  req, req_dividend, req_divisor,
        output ack, quotient, remainder, err, busy, grant_id
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: nearest active requester strictly after the last owner, with wrap.
module rr_arbiter
    import div_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_MAX
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [1:0]         last_i,
    output logic [1:0]         grant_o,
    output logic               valid_o
);

    logic [1:0] cand_s;
    logic       hit_s;

    // Walk offsets from farthest to nearest so the closest hit overwrites earlier ones
    always_comb begin
        grant_o = 2'd0;
        valid_o = 1'b0;
        cand_s  = 2'd0;
        hit_s   = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand_s  = rr_wrap({1'b0, last_i} + 3'(i), 3'(NUM_REQ));
            hit_s   = req_i[cand_s];
            grant_o = hit_s ? cand_s : grant_o;
            valid_o = valid_o | hit_s;
        end
    end

endmodule

// File: rtl/div_rr_scheduler.sv
// Shares one external repeated-subtraction divider between up to four
// requesters. Owner is picked round-robin, operands are latched at grant,
// and the result returns as a one-cycle ack to that owner.
module div_rr_scheduler
    import div_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_MAX,
    parameter int WIDTH   = WIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    div_rr_scheduler_if.slave bus,
    output logic              LdA,
    output logic              LdB,
    output logic              LdD,
    output logic              clrCount,
    output logic              incCount,
    output logic              s,
    output logic [WIDTH-1:0]  data_in,
    input  logic              lesser,
    input  logic [WIDTH-1:0]  count,
    input  logic [WIDTH-1:0]  a_val
);

    localparam logic [NUM_REQ-1:0] ACK_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_e             state_q;
    logic [1:0]         owner_q;
    logic [1:0]         last_q;
    logic [WIDTH-1:0]   dividend_q;
    logic [WIDTH-1:0]   divisor_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [WIDTH-1:0]   quotient_q;
    logic [WIDTH-1:0]   remainder_q;
    logic               err_q;
    logic               busy_q;

    logic [1:0]         grant_s;
    logic               grant_valid_s;
    logic [WIDTH-1:0]   win_dividend_s;
    logic [WIDTH-1:0]   win_divisor_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i   (bus.req),
        .last_i  (last_q),
        .grant_o (grant_s),
        .valid_o (grant_valid_s)
    );

    // Select the operand slices of the requester the arbiter is proposing
    always_comb begin
        win_dividend_s = '0;
        win_divisor_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_dividend_s = (grant_s == 2'(i)) ? bus.req_dividend[i*WIDTH +: WIDTH] : win_dividend_s;
            win_divisor_s  = (grant_s == 2'(i)) ? bus.req_divisor[i*WIDTH +: WIDTH]  : win_divisor_s;
        end
    end

    // Control FSM with registered response outputs; ack is a single-cycle pulse during RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= 2'd0;
            last_q      <= 2'(NUM_REQ - 1);
            dividend_q  <= '0;
            divisor_q   <= '0;
            ack_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ack_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|bus.req) begin
                        state_q <= ST_ARB;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_ARB: begin
                    if (grant_valid_s) begin
                        owner_q    <= grant_s;
                        last_q     <= grant_s;
                        dividend_q <= win_dividend_s;
                        divisor_q  <= win_divisor_s;
                        if (win_divisor_s == '0) begin
                            // Divide-by-zero short-circuits straight to the response
                            state_q     <= ST_RESP;
                            ack_q       <= ACK_ONE << grant_s;
                            err_q       <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= win_dividend_s;
                        end else begin
                            state_q <= ST_LOAD_A;
                        end
                    end else begin
                        // Request vanished before arbitration; nothing to serve
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_LOAD_A: state_q <= ST_LOAD_B;
                ST_LOAD_B: state_q <= ST_SUB;
                ST_SUB: begin
                    if (lesser) begin
                        state_q     <= ST_RESP;
                        ack_q       <= ACK_ONE << owner_q;
                        err_q       <= 1'b0;
                        quotient_q  <= count;
                        remainder_q <= a_val;
                    end else begin
                        state_q <= ST_SUB;
                    end
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    err_q       <= 1'b0;
                    quotient_q  <= '0;
                    remainder_q <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath controls decode from the state register; SUB also needs the live
    // lesser compare, so it cannot be registered without costing a cycle per step
    always_comb begin
        LdA      = 1'b0;
        LdB      = 1'b0;
        LdD      = 1'b0;
        clrCount = 1'b0;
        incCount = 1'b0;
        s        = 1'b0;
        data_in  = '0;
        case (state_q)
            ST_LOAD_A: begin
                data_in  = dividend_q;
                LdA      = 1'b1;
                clrCount = 1'b1;
            end
            ST_LOAD_B: begin
                data_in = divisor_q;
                LdB     = 1'b1;
            end
            ST_SUB: begin
                if (lesser) begin
                    LdD = 1'b1;
                end else begin
                    s        = 1'b1;
                    LdA      = 1'b1;
                    incCount = 1'b1;
                end
            end
            default: begin
                data_in = '0;
            end
        endcase
    end

    assign bus.ack       = ack_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
    assign bus.grant_id  = owner_q;

endmodule

// File: tb/tb_div_rr_scheduler.sv
// Bench for div_rr_scheduler: emulates the external subtract datapath and
// compares every response against arithmetic and round-robin rules.
module tb_div_rr_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int MAXC = 1200;

    logic         clk = 1'b0;
    logic         rst;
    logic         LdA, LdB, LdD, clrCount, incCount, s, lesser;
    logic [W-1:0] data_in, count, a_val;
    logic [W-1:0] a_reg, b_reg, cnt_reg;

    logic [W-1:0] op_dvd [NREQ];
    logic [W-1:0] op_dvs [NREQ];
    int           m_last;
    int           ack_log [$];
    int           checks = 0;
    int           errors = 0;

    typedef struct {
        int           idx;
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         err;
        int           lat;
    } vec_t;
    vec_t vecs [9];

    div_rr_scheduler_if #(.NUM_REQ(NREQ), .WIDTH(W)) bus ();

    div_rr_scheduler #(.NUM_REQ(NREQ), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .LdA(LdA), .LdB(LdB), .LdD(LdD), .clrCount(clrCount), .incCount(incCount), .s(s),
        .data_in(data_in), .lesser(lesser), .count(count), .a_val(a_val)
    );

    always #5 clk = ~clk;

    // External datapath: A register with subtract, B register, quotient counter
    always_ff @(posedge clk) begin
        if (LdA) a_reg <= s ? (a_reg - b_reg) : data_in;
        if (LdB) b_reg <= data_in;
        if (clrCount) cnt_reg <= '0;
        else if (incCount) cnt_reg <= cnt_reg + 16'd1;
    end
    assign lesser = (a_reg < b_reg);
    assign a_val  = a_reg;
    assign count  = cnt_reg;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] pend, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (pend[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return 0;
    endfunction

    function automatic logic [W-1:0] model_q(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 16'd0) ? 16'hFFFF : a / b;
    endfunction

    function automatic logic [W-1:0] model_r(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 16'd0) ? a : a % b;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_dividend[i*W +: W] = op_dvd[i];
            bus.req_divisor[i*W +: W]  = op_dvs[i];
        end
    endtask

    // Counts busy cycles (ARB entry onwards) until an ack appears
    task automatic wait_ack(output int lat, output bit to, output bit lda);
        lat = 0; to = 1'b1; lda = 1'b0;
        for (int c = 0; c < MAXC; c++) begin
            @(negedge clk);
            if (bus.busy) lat++;
            if (LdA) lda = 1'b1;
            if (bus.ack != '0) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_last = NREQ - 1;
    endtask

    // Serves nops operations from the requesters in mask, checking each against the model
    task automatic run_batch(input string tag, input logic [NREQ-1:0] mask, input int nops, input bit keep);
        logic [NREQ-1:0] pend;
        int              e, lat, got_i;
        bit              to, lda;
        ack_log.delete();
        pend = mask;
        @(negedge clk);
        drive_ops();
        bus.req = mask;
        for (int n = 0; n < nops; n++) begin
            e = model_pick(pend, m_last);
            wait_ack(lat, to, lda);
            check($sformatf("%s_%0d_timeout", tag, n), 32'(to), 32'd0);
            if (to) begin
                bus.req = '0;
                return;
            end
            got_i = -1;
            for (int i = NREQ - 1; i >= 0; i--) if (bus.ack[i]) got_i = i;
            ack_log.push_back(got_i);
            check($sformatf("%s_%0d_ack", tag, n), 32'(bus.ack), 32'd1 << e);
            check($sformatf("%s_%0d_grant", tag, n), 32'(bus.grant_id), 32'(e));
            check($sformatf("%s_%0d_quot", tag, n), 32'(bus.quotient), 32'(model_q(op_dvd[e], op_dvs[e])));
            check($sformatf("%s_%0d_rem", tag, n), 32'(bus.remainder), 32'(model_r(op_dvd[e], op_dvs[e])));
            check($sformatf("%s_%0d_err", tag, n), 32'(bus.err), 32'(op_dvs[e] == 16'd0));
            check($sformatf("%s_%0d_lat", tag, n), 32'(lat),
                  (op_dvs[e] == 16'd0) ? 32'd2 : 32'(op_dvd[e] / op_dvs[e]) + 32'd5);
            check($sformatf("%s_%0d_lda", tag, n), 32'(lda), 32'(op_dvs[e] != 16'd0));
            m_last = e;
            if (!keep) begin
                pend[e]    = 1'b0;
                bus.req[e] = 1'b0;
            end
        end
        bus.req = '0;
    endtask

    initial begin
        int  lat;
        bit  to, lda, seen;
        logic [NREQ-1:0] m;

        vecs[0] = '{0, 16'd100,   16'd3,     16'd33,    16'd1,  1'b0, 38};
        vecs[1] = '{2, 16'd55,    16'd0,     16'hFFFF,  16'd55, 1'b1, 2};
        vecs[2] = '{3, 16'd9,     16'd4,     16'd2,     16'd1,  1'b0, 7};
        vecs[3] = '{1, 16'd7,     16'd7,     16'd1,     16'd0,  1'b0, 6};
        vecs[4] = '{0, 16'd5,     16'd9,     16'd0,     16'd5,  1'b0, 5};
        vecs[5] = '{1, 16'd0,     16'd5,     16'd0,     16'd0,  1'b0, 5};
        vecs[6] = '{3, 16'd65535, 16'd65535, 16'd1,     16'd0,  1'b0, 6};
        vecs[7] = '{2, 16'd0,     16'd0,     16'hFFFF,  16'd0,  1'b1, 2};
        vecs[8] = '{1, 16'd20,    16'd4,     16'd5,     16'd0,  1'b0, 10};

        rst = 1'b1;
        bus.req = '0;
        for (int i = 0; i < NREQ; i++) begin
            op_dvd[i] = '0;
            op_dvs[i] = '0;
        end
        drive_ops();
        @(negedge clk);
        @(negedge clk);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_quot", 32'(bus.quotient), 32'd0);
        check("rst_rem", 32'(bus.remainder), 32'd0);
        check("rst_grant", 32'(bus.grant_id), 32'd0);
        check("rst_ctrl", 32'({LdA, LdB, LdD, clrCount, incCount, s}), 32'd0);
        check("rst_data_in", 32'(data_in), 32'd0);
        rst = 1'b0;
        m_last = NREQ - 1;

        // Directed single-requester vectors with hand-computed results
        for (int v = 0; v < 9; v++) begin
            op_dvd[vecs[v].idx] = vecs[v].dvd;
            op_dvs[vecs[v].idx] = vecs[v].dvs;
            @(negedge clk);
            drive_ops();
            bus.req = 4'b0001 << vecs[v].idx;
            wait_ack(lat, to, lda);
            bus.req = '0;
            check($sformatf("vec%0d_timeout", v), 32'(to), 32'd0);
            check($sformatf("vec%0d_ack", v), 32'(bus.ack), 32'd1 << vecs[v].idx);
            check($sformatf("vec%0d_grant", v), 32'(bus.grant_id), 32'(vecs[v].idx));
            check($sformatf("vec%0d_quot", v), 32'(bus.quotient), 32'(vecs[v].q));
            check($sformatf("vec%0d_rem", v), 32'(bus.remainder), 32'(vecs[v].r));
            check($sformatf("vec%0d_err", v), 32'(bus.err), 32'(vecs[v].err));
            check($sformatf("vec%0d_lat", v), 32'(lat), 32'(vecs[v].lat));
            check($sformatf("vec%0d_lda", v), 32'(lda), 32'(!vecs[v].err));
            @(negedge clk);
            check($sformatf("vec%0d_ack_width", v), 32'(bus.ack), 32'd0);
            check($sformatf("vec%0d_idle", v), 32'(bus.busy), 32'd0);
            m_last = vecs[v].idx;
        end

        // All four requesters at once after reset: served 0,1,2,3
        do_reset();
        op_dvd[0] = 16'd10; op_dvs[0] = 16'd2;
        op_dvd[1] = 16'd20; op_dvs[1] = 16'd4;
        op_dvd[2] = 16'd7;  op_dvs[2] = 16'd7;
        op_dvd[3] = 16'd5;  op_dvs[3] = 16'd9;
        run_batch("all4", 4'b1111, 4, 1'b0);
        for (int k = 0; k < 4; k++)
            check($sformatf("all4_order%0d", k), 32'((k < ack_log.size()) ? ack_log[k] : -1), 32'(k));

        // Two requesters held high: grants alternate
        do_reset();
        op_dvd[0] = 16'd6; op_dvs[0] = 16'd3;
        op_dvd[1] = 16'd8; op_dvs[1] = 16'd2;
        run_batch("alt", 4'b0011, 4, 1'b1);
        for (int k = 0; k < 4; k++)
            check($sformatf("alt_order%0d", k), 32'((k < ack_log.size()) ? ack_log[k] : -1), 32'(k % 2));

        // Reset in the middle of a long SUB phase aborts without ack
        do_reset();
        op_dvd[1] = 16'd1000; op_dvs[1] = 16'd1;
        @(negedge clk);
        drive_ops();
        bus.req = 4'b0010;
        repeat (20) @(negedge clk);
        check("abort_busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        bus.req = '0;
        @(negedge clk);
        rst = 1'b0;
        m_last = NREQ - 1;
        check("abort_busy_after", 32'(bus.busy), 32'd0);
        check("abort_lda_after", 32'(LdA), 32'd0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.ack != '0) seen = 1'b1;
        end
        check("abort_no_ack", 32'(seen), 32'd0);
        op_dvd[3] = 16'd9; op_dvs[3] = 16'd4;
        run_batch("after_abort", 4'b1000, 1, 1'b0);

        // Request dropped after grant and operands changed mid-SUB
        op_dvd[2] = 16'd50; op_dvs[2] = 16'd7;
        @(negedge clk);
        drive_ops();
        bus.req = 4'b0100;
        lat = 0; to = 1'b1;
        for (int c = 0; c < MAXC; c++) begin
            @(negedge clk);
            if (bus.busy) lat++;
            if (lat == 2) bus.req[2] = 1'b0;
            if (lat == 6) begin
                op_dvd[2] = 16'd999; op_dvs[2] = 16'd1;
                drive_ops();
            end
            if (bus.ack != '0) begin
                to = 1'b0;
                break;
            end
        end
        check("drop_timeout", 32'(to), 32'd0);
        check("drop_ack", 32'(bus.ack), 32'd4);
        check("drop_quot", 32'(bus.quotient), 32'd7);
        check("drop_rem", 32'(bus.remainder), 32'd1);
        check("drop_err", 32'(bus.err), 32'd0);
        check("drop_lat", 32'(lat), 32'd12);
        m_last = 2;

        // Random single requests
        for (int t = 0; t < 20; t++) begin
            int idx;
            idx = int'($urandom_range(0, NREQ - 1));
            op_dvd[idx] = 16'($urandom_range(0, 400));
            op_dvs[idx] = 16'($urandom_range(0, 15));
            run_batch($sformatf("rs%0d", t), 4'b0001 << idx, 1, 1'b0);
        end

        // Random contending batches
        for (int t = 0; t < 12; t++) begin
            m = 4'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                op_dvd[i] = 16'($urandom_range(0, 200));
                op_dvs[i] = 16'($urandom_range(0, 9));
            end
            run_batch($sformatf("rb%0d", t), m, $countones(m), 1'b0);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_rr_scheduler.md
DIV_RR_SCHEDULER -- requirements
Module: div_rr_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters; legal values are 2..4.
REQ-002 The block SHALL have parameter WIDTH, default 16, giving the operand and result width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req, input, NUM_REQ bits: per-requester request level.
REQ-006 The block SHALL have port req_dividend, input, NUM_REQ*WIDTH bits: requester i uses slice [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port req_divisor, input, NUM_REQ*WIDTH bits, sliced the same way as req_dividend.
REQ-008 The block SHALL have port ack, output, NUM_REQ bits: one-cycle completion pulse to the granted requester.
REQ-009 The block SHALL have port quotient, output, WIDTH bits, valid only while any ack bit is high.
REQ-010 The block SHALL have port remainder, output, WIDTH bits, valid only while any ack bit is high.
REQ-011 The block SHALL have port err, output, 1 bit: divide-by-zero flag, valid with ack.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port grant_id, output, 2 bits: index of the current owner, valid while busy.
REQ-014 The block SHALL have datapath control outputs LdA, LdB, LdD, clrCount, incCount and s, each 1 bit.
REQ-015 The block SHALL have datapath output data_in, WIDTH bits.
REQ-016 The block SHALL have datapath inputs lesser (1 bit, A<B), count (WIDTH bits) and a_val (WIDTH bits, A register).

Function
REQ-017 The FSM SHALL have states IDLE, ARB, LOAD_A, LOAD_B, SUB and RESP.
REQ-018 IDLE SHALL go to ARB when any req bit is high; otherwise it SHALL stay in IDLE.
REQ-019 ARB SHALL register the owner using round-robin order, searching upward from the index after the last owner with wrap; after reset the search starts at index 0.
REQ-020 ARB SHALL latch the owner's operands into internal registers; later operand changes are ignored.
REQ-021 ARB with a latched divisor of 0 SHALL go to RESP with err=1, quotient all-ones and remainder=dividend, issuing no datapath loads.
REQ-022 LOAD_A SHALL drive data_in=dividend, s=0, LdA=1, clrCount=1 for one cycle.
REQ-023 LOAD_B SHALL drive data_in=divisor, LdB=1 for one cycle.
REQ-024 SUB with lesser=0 SHALL assert s=1, LdA=1 and incCount=1 and stay in SUB.
REQ-025 SUB with lesser=1 SHALL assert LdD=1 and go to RESP.
REQ-026 RESP SHALL pulse ack[owner] for exactly one cycle with quotient=count, remainder=a_val and err=0, then return to IDLE.
REQ-027 Latency SHALL be Q+5 cycles from ARB entry to the ack cycle inclusive, where Q is the true quotient; for divisor 0 it SHALL be 2 cycles.
REQ-028 All datapath controls SHALL be 0 and data_in 0 in every state not listed above.
REQ-029 A requester that drops req mid-operation SHALL still receive its ack pulse, and the operation SHALL NOT be aborted.
REQ-030 A requester SHALL hold req until ack; if req is still high after ack, that requester is re-arbitrated in the normal round-robin order.
REQ-031 Simultaneous requests SHALL be served one per operation, so no requester waits more than NUM_REQ-1 operations.
REQ-032 req bits at index NUM_REQ or above do not exist; grant_id SHALL never exceed NUM_REQ-1.

Reset
REQ-033 While rst=1 at a clock edge, the block SHALL enter IDLE and clear all outputs to 0.
REQ-034 Reset SHALL set the round-robin pointer so that index 0 has highest priority and clear the latched operands.
REQ-035 Reset during any state SHALL abort the operation with no ack; the datapath holds stale data, which the next LOAD_A clears.

Structure
REQ-036 Package div_sched_pkg SHALL hold the state enum, WIDTH_DEF=16 and NUM_REQ_MAX=4.
REQ-037 Round-robin selection SHALL be a sub-module rr_arbiter with inputs req and last-owner pointer, and outputs grant index and valid.
REQ-038 The FSM, operand latches and output registers SHALL stay in div_rr_scheduler; the subtract datapath is external.

Verification
REQ-039 Single request: req0 with 100/3 -> ack[0] after 38 cycles, quotient 33, remainder 1, err 0.
REQ-040 All four requesters raise req in the same cycle (operands 10/2, 20/4, 7/7, 5/9) -> acks in order 0,1,2,3; results 5r0, 5r0, 1r0, 0r5.
REQ-041 Divide by zero: req2 with 55/0 -> ack[2] two cycles after ARB, err 1, quotient 0xFFFF, remainder 55, LdA never asserted.
REQ-042 req1 held high with req0 re-requesting -> grants alternate 0,1,0,1 with no starvation.
REQ-043 rst pulsed in SUB during 1000/1 -> no ack, busy 0 next cycle; the following req3 with 9/4 -> quotient 2, remainder 1.
REQ-044 req dropped after ARB and dividend changed mid-SUB -> ack still pulses with the result of the latched operands.
